// File: rtl/zjh_disp_scan.sv
// Multiplexed scan controller for an NDIG-digit 7-segment display (4511 + 138 stage).
// Optional leading-zero suppression is compiled in with `define ZJH_LZ_BLANK_EN.
module zjh_disp_scan #(
    parameter int unsigned NDIG      = 8,
    parameter int unsigned DIV       = 1000,
    parameter int unsigned GAP       = 4,
    parameter int unsigned LT_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [4*NDIG-1:0]   DataIn,
    input  logic                LOAD,
    input  logic [NDIG-1:0]     Blank,
    output logic [3:0]          D,
    output logic                LE,
    output logic                BI,
    output logic                LT,
    output logic [2:0]          SEL,
    output logic                EN_N,
    output logic                FRAME
);

    localparam int unsigned MAXP = (DIV > GAP) ? ((DIV > LT_CYCLES) ? DIV : LT_CYCLES)
                                               : ((GAP > LT_CYCLES) ? GAP : LT_CYCLES);
    localparam int unsigned CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam bit          NO_GAP = (GAP == 0);

    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] LT_LAST  = CW'(LT_CYCLES - 1);
    localparam logic [IW-1:0] K_LAST   = IW'(NDIG - 1);

    typedef enum logic [1:0] {S_RESET, S_LAMP, S_SHOW, S_GAP} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          k, k_n, k_inc;
    logic [NDIG-1:0][3:0]   act, act_n, shd, shd_n;
    logic [NDIG-1:0]        lz;
    logic                   adv, bnd;
    logic [3:0]             d_n;
    logic                   bi_n, lt_n, en_n_n, frame_n;
    logic [2:0]             sel_n;

    assign LE = 1'b0;

`ifdef ZJH_LZ_BLANK_EN
    // Zeros above the most significant nonzero digit; digit 0 always shown.
    function automatic logic [NDIG-1:0] lz_mask(input logic [NDIG-1:0][3:0] v);
        logic [NDIG-1:0] m;
        logic            lead;
        m    = '0;
        lead = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            lead = lead & (v[i] == 4'd0);
            m[i] = lead;
        end
        return m;
    endfunction
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_RESET;
            cnt   <= '0;
            k     <= '0;
            act   <= '0;
            shd   <= '0;
            D     <= 4'd0;
            BI    <= 1'b0;
            LT    <= 1'b1;
            SEL   <= 3'd0;
            EN_N  <= 1'b1;
            FRAME <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            k     <= k_n;
            act   <= act_n;
            shd   <= shd_n;
            D     <= d_n;
            BI    <= bi_n;
            LT    <= lt_n;
            SEL   <= sel_n;
            EN_N  <= en_n_n;
            FRAME <= frame_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        d_n     = D;
        bi_n    = BI;
        lt_n    = LT;
        sel_n   = SEL;
        en_n_n  = EN_N;
        frame_n = 1'b0;
        shd_n   = LOAD ? DataIn : shd;
        act_n   = act;

        k_inc = (k == K_LAST) ? '0 : k + IW'(1);
        adv   = (state == S_SHOW && cnt == DIV_LAST && NO_GAP) ||
                (state == S_GAP  && cnt == GAP_LAST);
        bnd   = adv && (k == K_LAST);

        // A LOAD landing on the frame boundary bypasses the shadow straight to display.
        if (bnd) begin
            act_n = LOAD ? DataIn : shd;
        end

`ifdef ZJH_LZ_BLANK_EN
        lz = lz_mask(act_n);
`else
        lz = '0;
`endif

        case (state)
            S_RESET: begin
                state_n = S_LAMP;
                cnt_n   = '0;
                k_n     = '0;
                sel_n   = 3'd0;
                lt_n    = 1'b0;
                bi_n    = 1'b1;
                en_n_n  = 1'b0;
            end
            S_LAMP: begin
                if (cnt == LT_LAST) begin
                    state_n = S_SHOW;
                    cnt_n   = '0;
                    k_n     = '0;
                    sel_n   = 3'd0;
                    d_n     = act_n[0];
                    lt_n    = 1'b1;
                    en_n_n  = 1'b0;
                    bi_n    = ~(Blank[0] | lz[0]);
                end else begin
                    cnt_n = cnt + CW'(1);
                    k_n   = k_inc;
                    sel_n = 3'(k_inc);
                end
            end
            S_SHOW: begin
                if (cnt != DIV_LAST) begin
                    cnt_n = cnt + CW'(1);
                    bi_n  = ~(Blank[k] | lz[k]);
                end else if (!NO_GAP) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                    en_n_n  = 1'b1;
                    bi_n    = 1'b0;
                end
            end
            S_GAP: begin
                if (cnt != GAP_LAST) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_RESET;
            end
        endcase

        // Step to the next digit's SHOW slot; FRAME marks the wrap back to digit 0.
        if (adv) begin
            state_n = S_SHOW;
            cnt_n   = '0;
            k_n     = k_inc;
            sel_n   = 3'(k_inc);
            d_n     = act_n[k_inc];
            lt_n    = 1'b1;
            en_n_n  = 1'b0;
            bi_n    = ~(Blank[k_inc] | lz[k_inc]);
            frame_n = bnd;
        end
    end

endmodule
